apb_master_arb: RTL and testbench

- Multi-requester APB master: shares one APB master port between NUM_REQ internal requesters (CPU bridge, DMA, debug) using round-robin arbitration.
- Sequences the APB SETUP/ACCESS phases and returns the response to the granted requester.
- Aborts transfers that get no pready within TIMEOUT_CYCLES.
- Drives the master side of the team's APB interface, in front of the timer/peripheral slaves.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_master_arb_if.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/apb_master_arb.sv | 195 +++++++++++++++++++
 tb/tb_apb_master_arb.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the multi-requester APB master.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   localparam int APB_DEFAULT_TIMEOUT = 256;

   // Timeout counter width; a disabled timeout still gets a 1-bit counter.
   function automatic int cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bus bundle between the arbitrated master and the peripheral slaves.
interface apb_master_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pwrite;
   logic              psel;
   logic              penable;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output paddr, pwdata, pwrite, psel, penable,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, pwdata, pwrite, psel, penable,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible request scanning from ptr+1 with wrap.
module rr_arbiter #(
   parameter int  NUM_REQ = 3,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [NUM_REQ-1:0] eligible;

   assign eligible = req & ~mask;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int j;
         j = (int'(ptr) + k) % NUM_REQ;
         if (!grant_valid && eligible[j]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(j);
            grant[j]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB master port between NUM_REQ requesters with round-robin grant and ACCESS timeout.
module apb_master_arb
   import apb_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
   input  logic                               pclk,
   input  logic                               preset,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata,
   input  logic [NUM_REQ-1:0]                 req_write,
   output logic [NUM_REQ-1:0]                 rsp_valid,
   output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
   output logic                               rsp_err,
   output logic                               timeout_evt,
   apb_master_arb_if.master                   apb
);

   localparam int                IDX_W    = $clog2(NUM_REQ);
   localparam int                CNT_W    = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0]  PTR_INIT = IDX_W'(NUM_REQ - 1);

   apb_state_e                 state_reg, state_next;
   logic [IDX_W-1:0]           gnt_reg, gnt_next;
   logic [IDX_W-1:0]           ptr_reg, ptr_next;
   logic [CNT_W-1:0]           cnt_reg, cnt_next;
   logic [APB_ADDR_WIDTH-1:0]  paddr_reg, paddr_next;
   logic [APB_DATA_WIDTH-1:0]  pwdata_reg, pwdata_next;
   logic                       pwrite_reg, pwrite_next;
   logic                       psel_reg, psel_next;
   logic                       penable_reg, penable_next;
   logic [NUM_REQ-1:0]         rsp_valid_reg, rsp_valid_next;
   logic [APB_DATA_WIDTH-1:0]  rsp_rdata_reg, rsp_rdata_next;
   logic                       rsp_err_reg, rsp_err_next;
   logic                       timeout_evt_reg, timeout_evt_next;

   logic [NUM_REQ-1:0]         arb_mask;
   logic [NUM_REQ-1:0]         arb_grant;
   logic [IDX_W-1:0]           arb_idx;
   logic                       arb_valid;

   logic [APB_ADDR_WIDTH-1:0]  addr_terms  [NUM_REQ];
   logic [APB_DATA_WIDTH-1:0]  wdata_terms [NUM_REQ];
   logic [APB_ADDR_WIDTH-1:0]  sel_addr;
   logic [APB_DATA_WIDTH-1:0]  sel_wdata;
   logic                       sel_write;
   logic                       do_load;
   logic                       timeout_hit;

   // The just-served requester sits out only the back-to-back decision at completion.
   assign arb_mask = (state_reg == ACCESS) ? (NUM_REQ'(1) << gnt_reg) : '0;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req         (req_valid),
      .mask        (arb_mask),
      .ptr         (ptr_reg),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
         assign addr_terms[gi]  = {APB_ADDR_WIDTH{arb_grant[gi]}} & req_addr[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
         assign wdata_terms[gi] = {APB_DATA_WIDTH{arb_grant[gi]}} & req_wdata[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
   endgenerate

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_addr  = sel_addr | addr_terms[i];
         sel_wdata = sel_wdata | wdata_terms[i];
      end
      sel_write = |(arb_grant & req_write);
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);

   always_comb begin
      state_next       = state_reg;
      gnt_next         = gnt_reg;
      ptr_next         = ptr_reg;
      cnt_next         = cnt_reg;
      paddr_next       = paddr_reg;
      pwdata_next      = pwdata_reg;
      pwrite_next      = pwrite_reg;
      psel_next        = psel_reg;
      penable_next     = penable_reg;
      rsp_valid_next   = '0;
      rsp_rdata_next   = rsp_rdata_reg;
      rsp_err_next     = rsp_err_reg;
      timeout_evt_next = 1'b0;
      do_load          = 1'b0;

      case (state_reg)
         IDLE: begin
            do_load = arb_valid;
         end
         SETUP: begin
            penable_next = 1'b1;
            cnt_next     = '0;
            state_next   = ACCESS;
         end
         ACCESS: begin
            if (apb.pready) begin
               rsp_valid_next[gnt_reg] = 1'b1;
               rsp_rdata_next          = apb.prdata;
               rsp_err_next            = apb.pslverr;
               ptr_next                = gnt_reg;
               penable_next            = 1'b0;
               psel_next               = 1'b0;
               state_next              = IDLE;
               do_load                 = arb_valid;
            end else if (timeout_hit) begin
               rsp_valid_next[gnt_reg] = 1'b1;
               rsp_rdata_next          = '0;
               rsp_err_next            = 1'b1;
               timeout_evt_next        = 1'b1;
               ptr_next                = gnt_reg;
               penable_next            = 1'b0;
               psel_next               = 1'b0;
               state_next              = IDLE;
            end else if (cnt_reg != '1) begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (do_load) begin
         gnt_next     = arb_idx;
         paddr_next   = sel_addr;
         pwdata_next  = sel_wdata;
         pwrite_next  = sel_write;
         psel_next    = 1'b1;
         penable_next = 1'b0;
         state_next   = SETUP;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_reg       <= IDLE;
         gnt_reg         <= '0;
         ptr_reg         <= PTR_INIT;
         cnt_reg         <= '0;
         paddr_reg       <= '0;
         pwdata_reg      <= '0;
         pwrite_reg      <= 1'b0;
         psel_reg        <= 1'b0;
         penable_reg     <= 1'b0;
         rsp_valid_reg   <= '0;
         rsp_rdata_reg   <= '0;
         rsp_err_reg     <= 1'b0;
         timeout_evt_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         gnt_reg         <= gnt_next;
         ptr_reg         <= ptr_next;
         cnt_reg         <= cnt_next;
         paddr_reg       <= paddr_next;
         pwdata_reg      <= pwdata_next;
         pwrite_reg      <= pwrite_next;
         psel_reg        <= psel_next;
         penable_reg     <= penable_next;
         rsp_valid_reg   <= rsp_valid_next;
         rsp_rdata_reg   <= rsp_rdata_next;
         rsp_err_reg     <= rsp_err_next;
         timeout_evt_reg <= timeout_evt_next;
      end
   end

   assign apb.paddr   = paddr_reg;
   assign apb.pwdata  = pwdata_reg;
   assign apb.pwrite  = pwrite_reg;
   assign apb.psel    = psel_reg;
   assign apb.penable = penable_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_rdata   = rsp_rdata_reg;
   assign rsp_err     = rsp_err_reg;
   assign timeout_evt = timeout_evt_reg;

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: directed requests, a scripted APB slave, queued expectations.
module tb_apb_master_arb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 3;
   localparam int TO = 4;

   logic            pclk = 1'b0;
   logic            preset;
   logic [NR-1:0]   req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [NR-1:0]   req_write;
   logic [NR-1:0]   rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;
   logic            timeout_evt;

   apb_master_arb_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

   apb_master_arb #(
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .pclk        (pclk),
      .preset      (preset),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_write   (req_write),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .timeout_evt (timeout_evt),
      .apb         (apb)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        err;
      logic        tevt;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        write;
   } bus_t;

   rsp_t rsp_q[$];
   bus_t bus_q[$];
   int   rsp_times[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scripted slave: pready after sl_wait ACCESS cycles, or never when stuck.
   int          sl_wait = 0;
   bit          sl_stuck = 0;
   logic [31:0] sl_prdata = '0;
   logic        sl_err = 1'b0;
   int          sl_acc = 0;

   initial begin
      apb.pready  = 1'b0;
      apb.prdata  = '0;
      apb.pslverr = 1'b0;
   end

   always @(negedge pclk) begin
      apb.prdata  = sl_prdata;
      apb.pslverr = sl_err;
      if (apb.psel && apb.penable) begin
         apb.pready = !sl_stuck && (sl_acc == sl_wait);
         sl_acc++;
      end else begin
         apb.pready = 1'b0;
         sl_acc = 0;
      end
   end

   // Monitor: bus-phase and response scoreboards plus activity counters.
   int   psel_cnt = 0;
   int   penable_cnt = 0;
   int   psel_fall = 0;
   logic psel_prev = 1'b0;
   bus_t cur_bus;

   always @(negedge pclk) begin
      if (apb.psel) psel_cnt++;
      if (apb.penable) penable_cnt++;
      if (psel_prev && !apb.psel) psel_fall++;
      psel_prev = apb.psel;

      if (apb.psel && !apb.penable) begin
         if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_setup: got paddr 0x%0h expected no transfer", apb.paddr);
         end else begin
            cur_bus = bus_q.pop_front();
            chk("setup_paddr", 64'(apb.paddr), 64'(cur_bus.addr));
            chk("setup_pwdata", 64'(apb.pwdata), 64'(cur_bus.wdata));
            chk("setup_pwrite", 64'(apb.pwrite), 64'(cur_bus.write));
         end
      end else if (apb.psel && apb.penable) begin
         chk("access_paddr", 64'(apb.paddr), 64'(cur_bus.addr));
         chk("access_pwdata", 64'(apb.pwdata), 64'(cur_bus.wdata));
         chk("access_pwrite", 64'(apb.pwrite), 64'(cur_bus.write));
      end

      if (rsp_valid != '0 || timeout_evt) begin
         $display("rsp: valid=%b rdata=0x%08h err=%0d tevt=%0d", rsp_valid, rsp_rdata, rsp_err, timeout_evt);
         if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got rsp_valid %b expected none", rsp_valid);
         end else begin
            rsp_t e;
            logic [NR-1:0] one;
            e   = rsp_q.pop_front();
            one = 1;
            chk("rsp_valid", 64'(rsp_valid), 64'(one << e.idx));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("timeout_evt", 64'(timeout_evt), 64'(e.tevt));
         end
      end
   end

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic w);
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_write[i]          = w;
   endtask

   task automatic expect_xfer(input int i, input logic [31:0] rdata, input logic err, input logic tevt);
      bus_t b;
      rsp_t r;
      b.addr  = req_addr[i*AW +: AW];
      b.wdata = req_wdata[i*DW +: DW];
      b.write = req_write[i];
      r.idx   = i;
      r.rdata = rdata;
      r.err   = err;
      r.tevt  = tevt;
      bus_q.push_back(b);
      rsp_q.push_back(r);
   endtask

   // Requesters drop req_valid at the negedge of their target-th response.
   task automatic run_until(input logic [NR-1:0] who, input int target);
      int served [NR];
      bit done;
      for (int i = 0; i < NR; i++) served[i] = 0;
      rsp_times.delete();
      for (int k = 0; k < 300; k++) begin
         @(negedge pclk);
         for (int i = 0; i < NR; i++) begin
            if (rsp_valid[i]) begin
               served[i]++;
               rsp_times.push_back(k);
               if (served[i] >= target) req_valid[i] = 1'b0;
            end
         end
         done = 1'b1;
         for (int i = 0; i < NR; i++) if (who[i] && served[i] < target) done = 1'b0;
         if (done) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_rsp: got no completion within 300 cycles expected responses for %b", who);
      req_valid = '0;
   endtask

   int p0, e0, f0;

   initial begin
      preset    = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge pclk);

      chk("reset_psel", 64'(apb.psel), 64'd0);
      chk("reset_penable", 64'(apb.penable), 64'd0);
      chk("reset_paddr", 64'(apb.paddr), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("reset_timeout_evt", 64'(timeout_evt), 64'd0);
      preset = 1'b0;
      repeat (2) @(negedge pclk);

      // Single read, two wait states.
      sl_wait = 2;
      sl_prdata = 32'hDEAD_BEEF;
      set_req(1, 32'h1000_0004, 32'h0000_0000, 1'b0);
      expect_xfer(1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      p0 = psel_cnt;
      e0 = penable_cnt;
      req_valid[1] = 1'b1;
      run_until(3'b010, 1);
      repeat (3) @(negedge pclk);
      chk("read_psel_cycles", 64'(psel_cnt - p0), 64'd4);
      chk("read_penable_cycles", 64'(penable_cnt - e0), 64'd3);

      // Write answered with pslverr.
      sl_wait = 0;
      sl_err = 1'b1;
      sl_prdata = 32'h1234_5678;
      set_req(2, 32'h2000_0008, 32'h0000_00A5, 1'b1);
      expect_xfer(2, 32'h1234_5678, 1'b1, 1'b0);
      req_valid[2] = 1'b1;
      run_until(3'b100, 1);
      @(negedge pclk);
      sl_err = 1'b0;
      repeat (2) @(negedge pclk);

      // Timeout with pready stuck low.
      sl_stuck = 1'b1;
      sl_prdata = 32'hFFFF_FFFF;
      set_req(0, 32'h3000_0000, 32'h0000_0011, 1'b0);
      expect_xfer(0, 32'h0000_0000, 1'b1, 1'b1);
      p0 = psel_cnt;
      e0 = penable_cnt;
      req_valid[0] = 1'b1;
      run_until(3'b001, 1);
      chk("timeout_psel_after", 64'(apb.psel), 64'd0);
      repeat (3) @(negedge pclk);
      chk("timeout_access_cycles", 64'(penable_cnt - e0), 64'd4);
      chk("timeout_psel_cycles", 64'(psel_cnt - p0), 64'd5);
      sl_stuck = 1'b0;

      // All three requesters held valid from reset, zero-wait slave.
      sl_wait = 0;
      sl_prdata = 32'hCAFE_0000;
      set_req(0, 32'h0000_0100, 32'h0000_00A0, 1'b0);
      set_req(1, 32'h0000_0104, 32'h0000_00A1, 1'b0);
      set_req(2, 32'h0000_0108, 32'h0000_00A2, 1'b0);
      preset = 1'b1;
      req_valid = 3'b111;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++) expect_xfer(i, 32'hCAFE_0000, 1'b0, 1'b0);
      @(negedge pclk);
      p0 = psel_cnt;
      e0 = penable_cnt;
      f0 = psel_fall;
      preset = 1'b0;
      run_until(3'b111, 2);
      repeat (3) @(negedge pclk);
      chk("rr_rsp_count", 64'(rsp_times.size()), 64'd6);
      for (int i = 1; i < rsp_times.size(); i++)
         chk("rr_rsp_spacing", 64'(rsp_times[i] - rsp_times[i-1]), 64'd2);
      chk("rr_psel_cycles", 64'(psel_cnt - p0), 64'd12);
      chk("rr_penable_cycles", 64'(penable_cnt - e0), 64'd6);
      chk("rr_psel_falls", 64'(psel_fall - f0), 64'd1);

      // Only requester 1 valid: one IDLE cycle between its transfers.
      sl_prdata = 32'h5555_AAAA;
      set_req(1, 32'h4000_0010, 32'h0000_0077, 1'b1);
      for (int r = 0; r < 3; r++) expect_xfer(1, 32'h5555_AAAA, 1'b0, 1'b0);
      f0 = psel_fall;
      req_valid[1] = 1'b1;
      run_until(3'b010, 3);
      repeat (3) @(negedge pclk);
      chk("single_rsp_count", 64'(rsp_times.size()), 64'd3);
      for (int i = 1; i < rsp_times.size(); i++)
         chk("single_rsp_spacing", 64'(rsp_times[i] - rsp_times[i-1]), 64'd3);
      chk("single_psel_falls", 64'(psel_fall - f0), 64'd3);

      // Reset asserted during ACCESS, then requester 0 must win first.
      sl_wait = 10;
      set_req(1, 32'h5000_0000, 32'h0000_0033, 1'b0);
      begin
         bus_t b;
         b.addr  = 32'h5000_0000;
         b.wdata = 32'h0000_0033;
         b.write = 1'b0;
         bus_q.push_back(b);
      end
      req_valid[1] = 1'b1;
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge pclk);
            if (apb.penable) seen = 1'b1;
         end
         if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_access: got no ACCESS within 20 cycles expected penable");
         end
      end
      preset = 1'b1;
      req_valid = 3'b111;
      sl_wait = 0;
      sl_prdata = 32'h0BAD_F00D;
      #1;
      chk("midreset_psel", 64'(apb.psel), 64'd0);
      chk("midreset_penable", 64'(apb.penable), 64'd0);
      chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
      set_req(0, 32'h0000_0200, 32'h0000_00B0, 1'b0);
      set_req(2, 32'h0000_0208, 32'h0000_00B2, 1'b1);
      for (int i = 0; i < NR; i++) expect_xfer(i, 32'h0BAD_F00D, 1'b0, 1'b0);
      @(negedge pclk);
      preset = 1'b0;
      run_until(3'b111, 1);
      repeat (5) @(negedge pclk);

      chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
      chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
